// File: rtl/reorder_buffer_pkg.sv
// Shared widths and entry-type encodings for the reorder buffer and its bus.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH_BIT_DEF = 3;
    localparam int REG_ID_BIT_DEF    = 5;
    localparam int DATA_W            = 32;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_STORE  = 2'd1,
        ROB_TYPE_BRANCH = 2'd2,
        ROB_TYPE_OTHER  = 2'd3
    } rob_type_e;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, CDB, operand query, commit and flush signals of the reorder buffer.
// master = core side (dispatch/CDB/consumers), slave = the reorder buffer itself.
interface reorder_buffer_if
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF,
    parameter int REG_ID_BIT    = REG_ID_BIT_DEF
);
    logic                     issue_valid;
    rob_type_e                issue_type;
    logic [REG_ID_BIT-1:0]    issue_rd;
    logic                     issue_ready;
    logic [ROB_WIDTH_BIT-1:0] issue_rob_id;

    logic                     cdb_valid;
    logic [ROB_WIDTH_BIT-1:0] cdb_rob_id;
    logic [DATA_W-1:0]        cdb_value;
    logic                     cdb_mispredict;
    logic [DATA_W-1:0]        cdb_target;

    logic [ROB_WIDTH_BIT-1:0] query_id_a;
    logic [ROB_WIDTH_BIT-1:0] query_id_b;
    logic                     query_ready_a;
    logic                     query_ready_b;
    logic [DATA_W-1:0]        query_value_a;
    logic [DATA_W-1:0]        query_value_b;

    logic                     commit_reg_valid;
    logic [REG_ID_BIT-1:0]    commit_reg_id;
    logic [DATA_W-1:0]        commit_value;
    logic [ROB_WIDTH_BIT-1:0] commit_rob_id;
    logic                     commit_store_valid;
    logic [ROB_WIDTH_BIT-1:0] commit_store_rob_id;
    logic                     flush_out;
    logic [DATA_W-1:0]        flush_pc;

    modport master (
        output issue_valid, issue_type, issue_rd,
        input  issue_ready, issue_rob_id,
        output cdb_valid, cdb_rob_id, cdb_value, cdb_mispredict, cdb_target,
        output query_id_a, query_id_b,
        input  query_ready_a, query_ready_b, query_value_a, query_value_b,
        input  commit_reg_valid, commit_reg_id, commit_value, commit_rob_id,
        input  commit_store_valid, commit_store_rob_id, flush_out, flush_pc
    );

    modport slave (
        input  issue_valid, issue_type, issue_rd,
        output issue_ready, issue_rob_id,
        input  cdb_valid, cdb_rob_id, cdb_value, cdb_mispredict, cdb_target,
        input  query_id_a, query_id_b,
        output query_ready_a, query_ready_b, query_value_a, query_value_b,
        output commit_reg_valid, commit_reg_id, commit_value, commit_rob_id,
        output commit_store_valid, commit_store_rob_id, flush_out, flush_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement ring: tag at issue, CDB capture, one retire/cycle; commit/flush outputs one cycle after retire.
// issue_ready/query are combinational; rdy_in low freezes all state and holds every pulse output low.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF,
    parameter int REG_ID_BIT    = REG_ID_BIT_DEF
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave bus
);
    localparam int DEPTH = 1 << ROB_WIDTH_BIT;
    localparam logic [ROB_WIDTH_BIT:0] FULL_COUNT = (ROB_WIDTH_BIT + 1)'(DEPTH);

    logic [ROB_WIDTH_BIT-1:0] head;
    logic [ROB_WIDTH_BIT-1:0] tail;
    logic [ROB_WIDTH_BIT:0]   count;
    logic [DEPTH-1:0]         alloc;
    logic [DEPTH-1:0]         ready;
    logic [DEPTH-1:0]         mis_q;
    rob_type_e                type_q   [DEPTH];
    logic [REG_ID_BIT-1:0]    rd_q     [DEPTH];
    logic [DATA_W-1:0]        value_q  [DEPTH];
    logic [DATA_W-1:0]        target_q [DEPTH];

    logic full;
    logic empty;
    logic do_commit;
    logic do_flush;
    logic issue_fire;
    logic cdb_fire;
    logic bypass_a;
    logic bypass_b;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Retirement looks only at the registered ready bit, so a CDB write to
    // the head entry retires on the following cycle at the earliest.
    assign do_commit  = rdy_in && !empty && ready[head];
    assign do_flush   = do_commit && (type_q[head] == ROB_TYPE_BRANCH) && mis_q[head];
    assign issue_fire = rdy_in && bus.issue_valid && !full && !do_flush;
    assign cdb_fire   = rdy_in && bus.cdb_valid && alloc[bus.cdb_rob_id] && !do_flush;

    assign bus.issue_ready  = !full;
    assign bus.issue_rob_id = tail;

    assign bypass_a          = bus.cdb_valid && (bus.cdb_rob_id == bus.query_id_a);
    assign bus.query_ready_a = alloc[bus.query_id_a] && (ready[bus.query_id_a] || bypass_a);
    assign bus.query_value_a = bypass_a ? bus.cdb_value : value_q[bus.query_id_a];

    assign bypass_b          = bus.cdb_valid && (bus.cdb_rob_id == bus.query_id_b);
    assign bus.query_ready_b = alloc[bus.query_id_b] && (ready[bus.query_id_b] || bypass_b);
    assign bus.query_value_b = bypass_b ? bus.cdb_value : value_q[bus.query_id_b];

    // Payload storage needs no reset: alloc/ready qualify every read.
    always_ff @(posedge clk_in) begin
        if (issue_fire) begin
            type_q[tail] <= bus.issue_type;
            rd_q[tail]   <= bus.issue_rd;
            mis_q[tail]  <= 1'b0;
        end
        if (cdb_fire) begin
            value_q[bus.cdb_rob_id]  <= bus.cdb_value;
            mis_q[bus.cdb_rob_id]    <= bus.cdb_mispredict;
            target_q[bus.cdb_rob_id] <= bus.cdb_target;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head                    <= '0;
            tail                    <= '0;
            count                   <= '0;
            alloc                   <= '0;
            ready                   <= '0;
            bus.commit_reg_valid    <= 1'b0;
            bus.commit_reg_id       <= '0;
            bus.commit_value        <= '0;
            bus.commit_rob_id       <= '0;
            bus.commit_store_valid  <= 1'b0;
            bus.commit_store_rob_id <= '0;
            bus.flush_out           <= 1'b0;
            bus.flush_pc            <= '0;
        end else if (!rdy_in) begin
            bus.commit_reg_valid   <= 1'b0;
            bus.commit_store_valid <= 1'b0;
            bus.flush_out          <= 1'b0;
        end else begin
            bus.commit_reg_valid   <= 1'b0;
            bus.commit_store_valid <= 1'b0;
            bus.flush_out          <= 1'b0;

            if (do_flush) begin
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                alloc         <= '0;
                ready         <= '0;
                bus.flush_out <= 1'b1;
                bus.flush_pc  <= target_q[head];
            end else begin
                if (issue_fire) begin
                    alloc[tail] <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + ROB_WIDTH_BIT'(1);
                end
                if (cdb_fire) begin
                    ready[bus.cdb_rob_id] <= 1'b1;
                end
                if (do_commit) begin
                    alloc[head] <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + ROB_WIDTH_BIT'(1);
                    unique case (type_q[head])
                        ROB_TYPE_REG: begin
                            // x0 retires normally but never writes the register file.
                            bus.commit_reg_valid <= (rd_q[head] != '0);
                            bus.commit_reg_id    <= rd_q[head];
                            bus.commit_value     <= value_q[head];
                            bus.commit_rob_id    <= head;
                        end
                        ROB_TYPE_STORE: begin
                            bus.commit_store_valid  <= 1'b1;
                            bus.commit_store_rob_id <= head;
                        end
                        default: ;
                    endcase
                end
                unique case ({issue_fire, do_commit})
                    2'b10:   count <= count + (ROB_WIDTH_BIT + 1)'(1);
                    2'b01:   count <= count - (ROB_WIDTH_BIT + 1)'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule
